// File: rtl/loader_pkg.sv
// Shared types and widths for the program loader boot path.
package loader_pkg;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [2:0] {
    LEN_HI,
    LEN_LO,
    DATA_HI,
    DATA_LO,
    FILL,
    RUN,
    ERR
  } state_t;

endpackage

// File: rtl/word_assembler.sv
// Joins two big-endian stream bytes into a 16-bit word.
// The high byte is held in a register. The low byte passes straight through,
// so the word and its done pulse are valid on the edge that accepts the low byte.
module word_assembler
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_accept,
  input  logic              i_phase_lo,
  input  logic [BYTE_W-1:0] i_byte,
  output logic [WORD_W-1:0] o_word,
  output logic              o_done
);

  logic [BYTE_W-1:0] r_hi;

  // Capture the high byte when it is accepted.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_hi <= '0;
    end else if (i_accept && !i_phase_lo) begin
      r_hi <= i_byte;
    end
  end

  // Present the assembled word together with its completion strobe.
  always_comb begin
    o_word = {r_hi, i_byte};
    o_done = i_accept && i_phase_lo;
  end

endmodule

// File: rtl/program_loader.sv
// Boot loader that receives a length-prefixed program image over a byte-wide
// valid/ready stream. It writes the image into the program ROM, zero-fills the
// remaining ROM words, and then releases the CPU from reset.
module program_loader
  import loader_pkg::*;
#(
  parameter int unsigned rom_size = 22,
  parameter int unsigned addr_w   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  output logic              in_ready,
  output logic              rom_we,
  output logic [addr_w-1:0] rom_addr,
  output logic [WORD_W-1:0] rom_wdata,
  output logic              cpu_reset,
  output logic              loaded,
  output logic              error
);

  localparam logic [addr_w:0] ROM_SIZE_X = (addr_w + 1)'(rom_size);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [addr_w-1:0] r_idx;
  logic [addr_w-1:0] w_idx_nxt;
  logic [addr_w-1:0] r_n;
  logic [addr_w-1:0] w_n_nxt;
  logic              r_we;
  logic              w_we_nxt;
  logic [addr_w-1:0] r_addr;
  logic [addr_w-1:0] w_addr_nxt;
  logic [WORD_W-1:0] r_wdata;
  logic [WORD_W-1:0] w_wdata_nxt;

  logic              w_ready;
  logic              w_accept;
  logic              w_phase_lo;
  logic              w_done;
  logic [WORD_W-1:0] w_word;
  logic [addr_w:0]   w_idx_inc;
  logic              w_len_big;
  logic              w_len_zero;

  word_assembler u_asm (
    .clk        (clk),
    .reset      (reset),
    .i_accept   (w_accept),
    .i_phase_lo (w_phase_lo),
    .i_byte     (in_data),
    .o_word     (w_word),
    .o_done     (w_done)
  );

  // Handshake and status decode from the state register only.
  always_comb begin
    w_ready    = reset && ((r_state == LEN_HI) || (r_state == LEN_LO) ||
                           (r_state == DATA_HI) || (r_state == DATA_LO));
    w_accept   = in_valid && w_ready;
    w_phase_lo = (r_state == LEN_LO) || (r_state == DATA_LO);
    w_idx_inc  = {1'b0, r_idx} + (addr_w + 1)'(1);
    w_len_big  = 32'(w_word) > rom_size;
    w_len_zero = (w_word == '0);
  end

  // Next-state and next-value logic for the FSM, word index and ROM port.
  // r_idx serves as the word index k while data is loading and as the fill
  // address afterwards. Data loading finishes with k+1 == N, and filling
  // starts at address N, so the index continues without a reload.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_n_nxt     = r_n;
    w_we_nxt    = 1'b0;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
    unique case (r_state)
      LEN_HI: begin
        if (w_accept) w_state_nxt = LEN_LO;
      end
      LEN_LO: begin
        if (w_done) begin
          w_idx_nxt = '0;
          if (w_len_big) begin
            w_state_nxt = ERR;
          end else if (w_len_zero) begin
            w_state_nxt = FILL;
          end else begin
            w_n_nxt     = addr_w'(w_word);
            w_state_nxt = DATA_HI;
          end
        end
      end
      DATA_HI: begin
        if (w_accept) w_state_nxt = DATA_LO;
      end
      DATA_LO: begin
        if (w_done) begin
          w_we_nxt    = 1'b1;
          w_addr_nxt  = r_idx;
          w_wdata_nxt = w_word;
          w_idx_nxt   = w_idx_inc[addr_w-1:0];
          w_state_nxt = (w_idx_inc < {1'b0, r_n}) ? DATA_HI : FILL;
        end
      end
      FILL: begin
        if ({1'b0, r_idx} < ROM_SIZE_X) begin
          w_we_nxt    = 1'b1;
          w_addr_nxt  = r_idx;
          w_wdata_nxt = '0;
          w_idx_nxt   = w_idx_inc[addr_w-1:0];
        end else begin
          w_state_nxt = RUN;
        end
      end
      RUN, ERR: begin
      end
      default: w_state_nxt = LEN_HI;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) r_state <= LEN_HI;
    else        r_state <= w_state_nxt;
  end

  // Index, length and registered ROM write port.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_idx   <= '0;
      r_n     <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_idx   <= w_idx_nxt;
      r_n     <= w_n_nxt;
      r_we    <= w_we_nxt;
      r_addr  <= w_addr_nxt;
      r_wdata <= w_wdata_nxt;
    end
  end

  // Drive the output ports.
  always_comb begin
    in_ready  = w_ready;
    rom_we    = r_we;
    rom_addr  = r_addr;
    rom_wdata = r_wdata;
    cpu_reset = (r_state != RUN);
    loaded    = (r_state == RUN);
    error     = (r_state == ERR);
  end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader. Each scenario queues its expected ROM
// writes. A negedge monitor pops one entry per rom_we pulse and compares it.
module tb_program_loader;
  import loader_pkg::*;

  localparam int unsigned ROM = 22;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        rom_we;
  logic [15:0] rom_addr;
  logic [15:0] rom_wdata;
  logic        cpu_reset;
  logic        loaded;
  logic        error;

  always #5 clk = ~clk;

  program_loader #(.rom_size(ROM), .addr_w(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .rom_we    (rom_we),
    .rom_addr  (rom_addr),
    .rom_wdata (rom_wdata),
    .cpu_reset (cpu_reset),
    .loaded    (loaded),
    .error     (error)
  );

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] d;
  } wr_t;

  wr_t  exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   wr_cnt = 0;
  logic prev_loaded = 1'b0;
  logic prev_last = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every write pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rom_we === 1'b1) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected none", rom_addr, rom_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", {16'h0, rom_addr}, {16'h0, e.a});
        chk("wr_data", {16'h0, rom_wdata}, {16'h0, e.d});
      end
    end
    if (loaded === 1'b1 && prev_loaded !== 1'b1)
      chk("run_after_last_write", {31'h0, prev_last}, 32'h1);
    prev_loaded = loaded;
    prev_last   = (rom_we === 1'b1) && (rom_addr == 16'(ROM - 1));
  end

  task automatic push_wr(input int unsigned a, input logic [15:0] d);
    wr_t e;
    e.a = 16'(a);
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic push_fill(input int unsigned from);
    for (int unsigned a = from; a < ROM; a++) push_wr(a, 16'h0000);
  endtask

  task automatic send(input logic [7:0] b, input int unsigned gap);
    bit acc;
    acc = 1'b0;
    repeat (gap) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 8'($urandom);
    end
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = b;
      acc      = in_ready;
      @(posedge clk);
    end
    if (!acc) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: byte %0h never accepted", b);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b0;
    @(negedge clk);
    reset  = 1'b1;
    wr_cnt = 0;
  endtask

  task automatic finish_load(input string nm, input int exp_cnt);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (loaded === 1'b1) done = 1'b1;
    end
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout: loaded never rose", nm);
    end
    chk({nm, "_loaded"}, {31'h0, loaded}, 32'h1);
    chk({nm, "_cpu_reset"}, {31'h0, cpu_reset}, 32'h0);
    chk({nm, "_error"}, {31'h0, error}, 32'h0);
    chk({nm, "_in_ready"}, {31'h0, in_ready}, 32'h0);
    chk({nm, "_wr_cnt"}, 32'(wr_cnt), 32'(exp_cnt));
    chk({nm, "_pending"}, 32'(exp_q.size()), 32'h0);
  endtask

  task automatic normal_image(input bit bursty);
    logic [7:0] img [8];
    img = '{8'h00, 8'h03, 8'h00, 8'h02, 8'hEC, 8'h10, 8'h00, 8'h00};
    push_wr(0, 16'h0002);
    push_wr(1, 16'hEC10);
    push_wr(2, 16'h0000);
    push_fill(3);
    for (int i = 0; i < 8; i++) send(img[i], bursty ? $urandom_range(0, 2) : 0);
    idle();
  endtask

  initial begin
    // Values held during reset.
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rom_we", {31'h0, rom_we}, 32'h0);
    chk("rst_rom_addr", {16'h0, rom_addr}, 32'h0);
    chk("rst_rom_wdata", {16'h0, rom_wdata}, 32'h0);
    chk("rst_cpu_reset", {31'h0, cpu_reset}, 32'h1);
    chk("rst_loaded", {31'h0, loaded}, 32'h0);
    chk("rst_error", {31'h0, error}, 32'h0);
    chk("rst_in_ready", {31'h0, in_ready}, 32'h0);
    reset = 1'b1;
    #1;
    chk("rel_in_ready", {31'h0, in_ready}, 32'h1);

    // Normal three-word image.
    normal_image(1'b0);
    finish_load("normal", 22);

    // Empty image.
    do_reset();
    push_fill(0);
    send(8'h00, 0);
    send(8'h00, 0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("empty_in_ready", {31'h0, in_ready}, 32'h0);
    finish_load("empty", 22);

    // Oversized image: N = 23.
    do_reset();
    send(8'h00, 0);
    send(8'h17, 0);
    @(negedge clk);
    chk("over_error", {31'h0, error}, 32'h1);
    chk("over_in_ready", {31'h0, in_ready}, 32'h0);
    chk("over_cpu_reset", {31'h0, cpu_reset}, 32'h1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'(i);
    end
    idle();
    chk("over_error_hold", {31'h0, error}, 32'h1);
    chk("over_loaded", {31'h0, loaded}, 32'h0);
    chk("over_wr_cnt", 32'(wr_cnt), 32'h0);

    // Same image with gaps in in_valid.
    do_reset();
    normal_image(1'b1);
    finish_load("bursty", 22);

    // Reset after the second word has been written.
    do_reset();
    push_wr(0, 16'h0002);
    push_wr(1, 16'hEC10);
    send(8'h00, 0);
    send(8'h03, 0);
    send(8'h00, 0);
    send(8'h02, 0);
    send(8'hEC, 0);
    send(8'h10, 0);
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b0;
    #1;
    chk("mid_in_ready_rst", {31'h0, in_ready}, 32'h0);
    @(negedge clk);
    chk("mid_rom_we", {31'h0, rom_we}, 32'h0);
    chk("mid_rom_addr", {16'h0, rom_addr}, 32'h0);
    chk("mid_cpu_reset", {31'h0, cpu_reset}, 32'h1);
    chk("mid_pending", 32'(exp_q.size()), 32'h0);
    reset  = 1'b1;
    wr_cnt = 0;
    #1;
    chk("mid_in_ready_rel", {31'h0, in_ready}, 32'h1);
    push_wr(0, 16'h1234);
    push_fill(1);
    send(8'h00, 0);
    send(8'h01, 0);
    send(8'h12, 0);
    send(8'h34, 0);
    idle();
    finish_load("mid", 22);

    // Exact fit: N = rom_size, so no fill writes follow the data.
    do_reset();
    for (int unsigned i = 0; i < ROM; i++) push_wr(i, 16'hA500 + 16'(i));
    send(8'h00, 0);
    send(8'(ROM), 0);
    for (int unsigned i = 0; i < ROM; i++) begin
      send(8'hA5, 0);
      send(8'(i), 0);
    end
    idle();
    finish_load("exact", 22);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Upstream neighbour of the Hack computer: streams a program image over a byte-wide valid/ready link and writes it word-by-word into the program ROM.
- Zero-fills the unused ROM tail, then releases the CPU from reset.
- Replaces the simulation-only ROM file load with a synthesizable boot path. The CPU is held in reset until the image is complete.

Parameters:
- rom_size, 22, number of 16-bit ROM words. Legal range 1..65535.
- addr_w, 16, width of the ROM address and of the length field.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-low reset (0 = in reset).
- in_valid  in  1  byte available on in_data.
- in_data  in  8  stream byte.
- in_ready  out  1  loader can accept a byte.
- rom_we  out  1  ROM write strobe, one word per cycle.
- rom_addr  out  addr_w  ROM write address.
- rom_wdata  out  16  ROM write data.
- cpu_reset  out  1  active-high reset to the CPU.
- loaded  out  1  image complete; CPU running.
- error  out  1  image length exceeded rom_size.

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=LEN_HI; rom_we=0; rom_addr=0; rom_wdata=0; cpu_reset=1; loaded=0; error=0.
  - in_ready is forced to 0 while reset is low.
  - Reset mid-operation aborts the load. ROM contents already written are not restored.
- Stream format: 2-byte big-endian word count N, then N words, each sent as high byte then low byte.
- Handshake:
  - A byte is accepted on an edge where in_valid && in_ready.
  - in_ready = 1 only in LEN_HI, LEN_LO, DATA_HI, DATA_LO. It depends only on state, never on in_valid.
  - in_data is ignored when no transfer occurs. Gaps in in_valid have no effect.
- State transitions:
  - LEN_HI: on accept, latch N[15:8]; go to LEN_LO.
  - LEN_LO: on accept, form N.
    - N > rom_size: go to ERR.
    - N == 0: go to FILL with fill address 0.
    - Otherwise: go to DATA_HI with word index k=0.
  - DATA_HI: on accept, latch the high byte; go to DATA_LO.
  - DATA_LO: on accept, the next cycle drives rom_we=1, rom_addr=k, rom_wdata={hi,lo}.
    - k+1 < N: go to DATA_HI with k=k+1.
    - k+1 == N: go to FILL with fill address N.
  - FILL: each cycle with fill address < rom_size, drive rom_we=1, rom_addr=fill address, rom_wdata=0, and increment. When the fill address == rom_size, drive rom_we=0 and go to RUN.
  - RUN: terminal until reset. cpu_reset=0, loaded=1, rom_we=0.
  - ERR: terminal until reset. error=1, cpu_reset=1, in_ready=0, rom_we=0. No ROM writes ever occur for an oversized N.
- Output timing:
  - rom_we, rom_addr and rom_wdata are registered.
  - rom_we is a single-cycle pulse per word and is never high in two consecutive DATA-phase cycles. Minimum of 2 accepted bytes per word.
  - cpu_reset = (state != RUN); loaded = (state == RUN); error = (state == ERR). All three decode from the state register.
  - The CPU therefore leaves reset no earlier than the cycle after the last rom_we pulse.
  - For N == rom_size, FILL lasts exactly 1 cycle with no write.
- Widths:
  - k and the fill address are addr_w bits.
  - N is compared unsigned against rom_size, and the N > rom_size check is done before any write.
  - No counter wraps, because N ≤ rom_size ≤ 65535.

Decomposition:
- loader_pkg holds:
  - the state enum: LEN_HI, LEN_LO, DATA_HI, DATA_LO, FILL, RUN, ERR;
  - WORD_W=16 and BYTE_W=8.
- One sub-module, word_assembler: takes byte accept plus a phase input and returns a 16-bit word with a word-done pulse. It is reused for the length field and for data words.
- The FSM, counters and ROM-port registers live in program_loader.

Test Plan:
- Normal load: stream 00 03 00 02 EC 10 00 00, rom_size=22.
  - Expect writes (0,0x0002), (1,0xEC10), (2,0x0000).
  - Then 19 zero writes to addresses 3..21.
  - Then cpu_reset 1→0 and loaded=1 in the cycle after the write to addr 21.
  - Total rom_we pulses = 22.
- Empty image: stream 00 00.
  - Expect in_ready=0 after the 2nd byte.
  - Expect 22 consecutive zero writes (addr 0..21), then RUN.
- Oversize: stream 00 17 (N=23).
  - Expect error=1 and in_ready=0 from the next cycle, cpu_reset stays 1, zero rom_we pulses.
  - Further in_valid is ignored.
- Bursty valid: the same image as the first scenario, with in_valid toggling 1,0,0,1 randomly.
  - Expect an identical write sequence: same addr/data order and same count.
- Mid-load reset: drive reset=0 for 1 cycle after word 1 is written.
  - Expect rom_we=0, in_ready=0 during reset, state LEN_HI afterwards, cpu_reset=1.
  - A fresh stream 00 01 12 34 then writes (0,0x1234) and fills 1..21.
- Exact fit: N=22 with 22 words.
  - Expect the last data write at addr 21, no fill writes, one idle FILL cycle, then loaded=1.
